// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer.
// Frames are back-to-back while the FIFO holds data; tx, busy and in_ready are registered.
module uart_tx #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_F_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_F_W-1:0] FIFO_FULL = CNT_F_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [2:0]           idx_q;
  logic [7:0]           shift_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 in_ready_q;
  logic [CNT_F_W-1:0]   count_q;
  logic [CNT_F_W-1:0]   count_d;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [7:0]           mem_q [FIFO_DEPTH];

  logic bit_done;
  logic push;
  logic pop;
  logic idle_next;

  // Pop happens when idle or on the last stop-bit cycle, so frames chain with no gap.
  always_comb begin
    bit_done  = (bit_cnt_q == BIT_LAST);
    push      = in_valid && in_ready_q;
    pop       = (count_q != '0) &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
    idle_next = (count_q == '0) &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_F_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_F_W'(1);
    end
  end

  // FIFO storage; pointers are reset in the control block, so a push during rst is harmless.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // tx follows the state by one cycle, so the start edge lands two cycles after an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d < FIFO_FULL);
      busy_q     <= !idle_next || (count_d != '0);

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        shift_q  <= mem_q[rd_ptr_q];
      end

      if ((state_q == S_IDLE) || bit_done) begin
        bit_cnt_q <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (bit_done) begin
            state_q <= S_DATA;
            idx_q   <= '0;
          end
        end
        S_DATA: begin
          tx_q <= shift_q[idx_q];
          if (bit_done) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            state_q <= pop ? S_START : S_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 12 clocks per bit (1.15 MHz / 100 kbaud, rounded up from 11.5).
module tb_uart_tx;

  localparam int C = 12;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int         cyc;
  int         n_checks;
  int         n_fail;
  int         start_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx #(
    .CLK_HZ    (1_150_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    data_in  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || tx !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
    repeat (C) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    check_eq(tag, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check_eq(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    rx_q.delete();
    exp_q.delete();
  endtask

  // Line decoder: samples mid-bit after each falling edge, abandons the frame on reset.
  initial begin : mon
    logic       prev;
    logic [9:0] bits;
    bit         aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        bits    = '0;
        for (int n = 1; n <= 9 * C + C / 2; n++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (n % C == C / 2) bits[n / C] = tx;
        end
        if (!aborted) begin
          check_eq("mon_start_bit", 32'(bits[0]), 32'd0);
          check_eq("mon_stop_bit", 32'(bits[9]), 32'd1);
          rx_q.push_back(bits[8:1]);
        end
        prev = 1'b1;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [9:0] f;
    int         s0;
    int         lows;
    int         bad;
    int         b;
    int         guard;
    logic       expb;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    data_in  = 8'h99;
    in_valid = 1'b1;

    // Reset, with a push held during it that must be dropped
    repeat (5) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_push_dropped", 32'(fifo_count), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Single byte 0xA5: exact cycle-by-cycle waveform, falling edge 2 cycles after accept
    f = {1'b1, 8'hA5, 1'b0};
    push(8'hA5);
    exp_q.push_back(8'hA5);
    check_eq("a5_count", 32'(fifo_count), 32'd1);
    check_eq("a5_busy", 32'(busy), 32'd1);
    for (int k = 2; k <= 3 + 10 * C + 1; k++) begin
      @(negedge clk);
      expb = (k - 3 >= 0 && k - 3 < 10 * C) ? f[(k - 3) / C] : 1'b1;
      check_eq("a5_tx", 32'(tx), 32'(expb));
    end
    check_eq("a5_busy_end", 32'(busy), 32'd0);
    check_eq("a5_count_end", 32'(fifo_count), 32'd0);
    repeat (2) @(negedge clk);
    check_rx("a5_rx");

    // Back-to-back 0x00, 0xFF; second push coincides with the first pop
    s0 = start_q.size();
    @(negedge clk);
    data_in  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    data_in  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check_eq("b2b_count", 32'(fifo_count), 32'd1);
    wait_idle("b2b_idle", 40 * C);
    check_eq("b2b_frames", 32'(start_q.size() - s0), 32'd2);
    if (start_q.size() >= s0 + 2)
      check_eq("b2b_period", 32'(start_q[s0 + 1] - start_q[s0]), 32'(10 * C));
    check_rx("b2b_rx");

    // Overflow: 17 pushes while frame 1 is on the line, the 17th is dropped
    push(8'h3C);
    exp_q.push_back(8'h3C);
    repeat (3) @(negedge clk);
    check_eq("ovf_empty", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check_eq("ovf_ready", 32'(in_ready), 32'(i < 16));
      data_in  = 8'(8'h10 + i);
      in_valid = 1'b1;
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("ovf_count", 32'(fifo_count), 32'd16);
    check_eq("ovf_ready_low", 32'(in_ready), 32'd0);
    wait_idle("ovf_idle", 18 * 10 * C);
    check_rx("ovf_rx");

    // Mid-frame reset during data bit 3 with three bytes queued
    s0 = start_q.size();
    @(negedge clk);
    data_in  = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    data_in  = 8'h22;
    @(negedge clk);
    data_in  = 8'h33;
    @(negedge clk);
    data_in  = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4 * C + C / 2 - 2) @(negedge clk);
    check_eq("mid_count_pre", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_tx", 32'(tx), 32'd1);
    check_eq("mid_count", 32'(fifo_count), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst  = 1'b0;
    lows = 0;
    for (int k = 0; k < 30 * C; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_eq("mid_tx_quiet", 32'(lows), 32'd0);
    check_eq("mid_frames", 32'(start_q.size() - s0), 32'd1);
    check_rx("mid_rx");

    // Stream 0x00..0xFF under in_ready flow control; all frames must chain
    s0    = start_q.size();
    b     = 0;
    guard = 0;
    while (b < 256 && guard < 40000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        data_in  = 8'(b);
        in_valid = 1'b1;
        exp_q.push_back(8'(b));
        b++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("stream_pushed", 32'(b), 32'd256);
    wait_idle("stream_idle", 20 * 10 * C);
    bad = 0;
    for (int k = s0 + 1; k < start_q.size(); k++)
      if (start_q[k] - start_q[k - 1] != 10 * C) bad++;
    check_eq("stream_gaps", 32'(bad), 32'd0);
    check_rx("stream_rx");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port data_in  input  8  byte to queue for transmission.
REQ-007 SHALL have port in_valid  input  1  data_in is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port tx  output  1  serial line: idle high, registered.
REQ-010 SHALL have port busy  output  1  frame in progress or FIFO not empty.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte on the line.

Function
REQ-012 SHALL use CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, integer rounded; 434 at defaults.
REQ-013 SHALL send frames as 8N1: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), no parity.
REQ-014 SHALL hold every bit, including start and stop, on tx for exactly CLKS_PER_BIT cycles.
REQ-015 SHALL drive in_ready = (fifo_count < FIFO_DEPTH), derived from the registered count only and not from a same-cycle pop.
REQ-016 SHALL accept a byte on a clock edge where in_valid && in_ready; SHALL ignore data_in when in_ready is low and SHALL NOT corrupt queued data.
REQ-017 SHALL implement FIFO pointers that wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-018 SHALL implement state machine IDLE, START, DATA, STOP with a bit-cycle counter and a 3-bit data index.
REQ-019 IDLE: tx=1; if fifo_count != 0, pop head into the shift register, go to START, and drive tx=0 from the next cycle.
REQ-020 START: after CLKS_PER_BIT cycles, go to DATA with index 0 and put bit 0 on tx.
REQ-021 DATA: after CLKS_PER_BIT cycles per bit, advance the index; after bit 7, go to STOP with tx=1.
REQ-022 STOP: on the last stop-bit cycle, if fifo_count != 0, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-023 Back-to-back frames SHALL have a start-edge-to-start-edge period of exactly 10*CLKS_PER_BIT cycles.
REQ-024 A byte pushed into an empty FIFO while in IDLE SHALL produce a tx falling edge exactly 2 cycles after the accepting edge.
REQ-025 busy SHALL = (state != IDLE) || (fifo_count != 0).
REQ-026 rx-side or line feedback SHALL NOT influence the transmit path; the block is free-running once queued.

Reset
REQ-027 While rst is high: tx=1, state=IDLE, counters=0, FIFO pointers=0, fifo_count=0, busy=0, in_ready=1.
REQ-028 An rst asserted mid-frame SHALL abort the frame, drive tx high on the next edge, and discard all queued bytes; no partial frame SHALL resume.
REQ-029 A push coincident with rst SHALL be dropped.

Verification
REQ-030 Reset: hold rst 5 cycles -> tx=1, busy=0, in_ready=1, fifo_count=0.
REQ-031 Single byte: push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 434 cycles, then tx=1 and busy=0.
REQ-032 Back-to-back: push 0x00 then 0xFF on consecutive cycles -> two frames, second start edge exactly 4340 cycles after the first, no idle gap.
REQ-033 Overflow: push 17 bytes with FIFO_DEPTH=16 during frame 1 -> in_ready low at count 16, extra byte dropped, all accepted bytes emitted in order.
REQ-034 Mid-frame reset: assert rst during DATA bit 3 with 3 bytes queued -> tx=1 next cycle, fifo_count=0, no further frames.
REQ-035 Reference loopback: connect tx to the team's uart_rx (same CLK_HZ and BAUD) and send 0x00..0xFF -> every byte received intact and in order.
